// File: rtl/ssm_sample_buf.sv
// ssm_sample_buf: commit-on-tail sampled packet buffer with overflow/overlength drop; define SSM_SAMPLE_BUF_STAT_EN for out_pkt_num and buf_used
module ssm_sample_buf #(
  parameter int DEPTH_LOG2 = 8,
  parameter int MAX_PKT_WORDS = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cnt_rst,
  input  logic [133:0]        in_data,
  input  logic                in_data_wr,
  input  logic                in_valid,
  input  logic                in_valid_wr,
  output logic [133:0]        out_data,
  output logic                out_data_wr,
  output logic                out_valid,
  output logic                out_valid_wr,
  input  logic                out_alf,
`ifdef SSM_SAMPLE_BUF_STAT_EN
  output logic [31:0]         out_pkt_num,
  output logic [DEPTH_LOG2:0] buf_used,
`endif
  output logic [31:0]         drop_num,
  output logic [31:0]         err_num
);
  localparam int P = DEPTH_LOG2 + 1;
  localparam int W = $clog2(MAX_PKT_WORDS + 1);
  localparam logic [P-1:0] CAP = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [P-1:0] MAXP = P'(MAX_PKT_WORDS);
  localparam logic [W-1:0] LASTC = W'(MAX_PKT_WORDS - 1);
  typedef enum logic [1:0] {IN_IDLE, IN_WRITE, IN_DROP} in_st_t;
  typedef enum logic [1:0] {OUT_IDLE, OUT_RD, OUT_SEND} out_st_t;
  in_st_t in_state, in_nxt;
  out_st_t out_state, out_nxt;
  logic [133:0] mem [0:(1<<DEPTH_LOG2)-1];
  logic [133:0] rd_q;
  logic [P-1:0] wr_ptr, cmt_ptr, rd_ptr, wr_ptr_nxt, pkt_cnt, used, free;
  logic [W-1:0] wcnt, wcnt_nxt;
  logic we, re, commit, dec, drop_inc, err_inc, is_head, is_tail, good, last, rd_tail, sending;
  assign is_head = in_data[133:132] == 2'b01;
  assign is_tail = in_data[133:132] == 2'b10;
  assign good = in_valid_wr & in_valid;
  assign last = wcnt == LASTC;
  assign used = wr_ptr - rd_ptr;
  assign free = CAP - used;
  assign rd_tail = rd_q[133:132] == 2'b10;
  assign sending = out_state != OUT_IDLE;
  always_comb begin
    in_nxt = in_state;
    we = 1'b0;
    wr_ptr_nxt = wr_ptr;
    wcnt_nxt = wcnt;
    commit = 1'b0;
    drop_inc = 1'b0;
    err_inc = 1'b0;
    if (in_data_wr)
      case (in_state)
        IN_IDLE:
          if (is_head && free >= MAXP) begin
            we = 1'b1;
            wr_ptr_nxt = wr_ptr + 1'b1;
            wcnt_nxt = W'(1);
            in_nxt = IN_WRITE;
          end else if (is_head) begin
            drop_inc = 1'b1;
            in_nxt = IN_DROP;
          end
        IN_WRITE:
          if (is_head || (!is_tail && last)) begin
            wr_ptr_nxt = cmt_ptr;
            err_inc = 1'b1;
            in_nxt = IN_DROP;
          end else if (is_tail) begin
            we = good;
            wr_ptr_nxt = good ? wr_ptr + 1'b1 : cmt_ptr;
            commit = good;
            drop_inc = !good;
            in_nxt = IN_IDLE;
          end else begin
            we = 1'b1;
            wr_ptr_nxt = wr_ptr + 1'b1;
            wcnt_nxt = wcnt + 1'b1;
          end
        IN_DROP: in_nxt = is_tail ? IN_IDLE : IN_DROP;
        default: in_nxt = IN_IDLE;
      endcase
  end
  always_comb begin
    out_nxt = out_state;
    re = 1'b0;
    dec = 1'b0;
    case (out_state)
      OUT_IDLE: begin
        re = pkt_cnt != '0 && !out_alf;
        out_nxt = re ? OUT_RD : OUT_IDLE;
      end
      OUT_RD, OUT_SEND: begin
        re = !rd_tail;
        dec = rd_tail;
        out_nxt = rd_tail ? OUT_IDLE : OUT_SEND;
      end
      default: out_nxt = OUT_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr[DEPTH_LOG2-1:0]] <= in_data;
    if (re) rd_q <= mem[rd_ptr[DEPTH_LOG2-1:0]];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      in_state <= IN_IDLE;
      out_state <= OUT_IDLE;
      wr_ptr <= '0;
      cmt_ptr <= '0;
      rd_ptr <= '0;
      wcnt <= '0;
      pkt_cnt <= '0;
      out_data <= '0;
      out_data_wr <= 1'b0;
      out_valid <= 1'b0;
      out_valid_wr <= 1'b0;
      drop_num <= '0;
      err_num <= '0;
    end else begin
      in_state <= in_nxt;
      out_state <= out_nxt;
      wr_ptr <= wr_ptr_nxt;
      cmt_ptr <= commit ? wr_ptr_nxt : cmt_ptr;
      rd_ptr <= rd_ptr + P'(re);
      wcnt <= wcnt_nxt;
      pkt_cnt <= pkt_cnt + P'(commit) - P'(dec);
      out_data <= sending ? rd_q : '0;
      out_data_wr <= sending;
      out_valid <= sending & rd_tail;
      out_valid_wr <= sending & rd_tail;
      drop_num <= cnt_rst ? '0 : drop_num + 32'(drop_inc);
      err_num <= cnt_rst ? '0 : err_num + 32'(err_inc);
    end
`ifdef SSM_SAMPLE_BUF_STAT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_pkt_num <= '0;
      buf_used <= '0;
    end else begin
      out_pkt_num <= cnt_rst ? '0 : out_pkt_num + 32'(out_valid_wr);
      buf_used <= used;
    end
`endif
endmodule

// File: tb/tb_ssm_sample_buf.sv
// tb_ssm_sample_buf: table-driven packet vectors plus corner sequences for ssm_sample_buf
module tb_ssm_sample_buf;
  logic clk = 0, rst_n = 0, cnt_rst = 0;
  logic [133:0] in_data = '0;
  logic in_data_wr = 0, in_valid = 0, in_valid_wr = 0, out_alf = 0;
  logic [133:0] out_data;
  logic out_data_wr, out_valid, out_valid_wr;
  logic [31:0] drop_num, err_num;
`ifdef SSM_SAMPLE_BUF_STAT_EN
  logic [31:0] out_pkt_num;
  logic [8:0] buf_used;
`endif
  int total = 0, bad = 0, cyc = 0, rx_words = 0, rx_pkts = 0, exp_pkts = 0;
  int head_cyc = -1, tail_cyc = 0;
  logic [133:0] exp_q[$];
  typedef struct {
    int n;
    bit good;
    bit exp_out;
    int drop;
    int err;
  } vec_t;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  ssm_sample_buf dut (
    .clk(clk), .rst_n(rst_n), .cnt_rst(cnt_rst),
    .in_data(in_data), .in_data_wr(in_data_wr), .in_valid(in_valid), .in_valid_wr(in_valid_wr),
    .out_data(out_data), .out_data_wr(out_data_wr), .out_valid(out_valid), .out_valid_wr(out_valid_wr),
    .out_alf(out_alf),
`ifdef SSM_SAMPLE_BUF_STAT_EN
    .out_pkt_num(out_pkt_num), .buf_used(buf_used),
`endif
    .drop_num(drop_num), .err_num(err_num)
  );
  function automatic void check(input string name, input logic [133:0] act, input logic [133:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction
  always @(negedge clk) begin : mon
    logic [133:0] e;
    if (rst_n && out_data_wr) begin
      rx_words++;
      if (head_cyc < 0 && out_data[133:132] == 2'b01) head_cyc = cyc;
      if (out_valid_wr) rx_pkts++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got %0h want none", out_data);
      end else begin
        e = exp_q.pop_front();
        check("out_word", out_data, e);
        check("out_valid_wr", 134'(out_valid_wr), 134'(e[133:132] == 2'b10));
        check("out_valid", 134'(out_valid), 134'(out_valid_wr));
      end
    end
  end
  task automatic idle_in();
    in_data = '0;
    in_data_wr = 0;
    in_valid_wr = 0;
    in_valid = 0;
  endtask
  task automatic put_word(input logic [1:0] t, input logic [15:0] tag, input int i, input bit vwr, input bit v, input bit ex);
    @(negedge clk);
    in_data = {t, 100'b0, tag, 16'(i)};
    in_data_wr = 1;
    in_valid_wr = vwr;
    in_valid = v;
    if (t == 2'b10) tail_cyc = cyc;
    if (ex) exp_q.push_back(in_data);
    if (ex && t == 2'b10) exp_pkts++;
  endtask
  task automatic send_pkt(input int n, input bit good, input bit ex, input logic [15:0] tag);
    for (int i = 0; i < n; i++)
      put_word(i == 0 ? 2'b01 : i == n - 1 ? 2'b10 : 2'b11, tag, i, i == n - 1, (i == n - 1) && good, ex);
    @(negedge clk);
    idle_in();
    @(negedge clk);
  endtask
  task automatic wait_drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d want 0", exp_q.size());
    end
    repeat (4) @(negedge clk);
  endtask
  initial begin
    vec_t v[8];
    int rx0;
    v[0] = '{6, 1, 1, 0, 0};
    v[1] = '{5, 0, 0, 1, 0};
    v[2] = '{4, 1, 1, 1, 0};
    v[3] = '{40, 1, 0, 1, 1};
    v[4] = '{3, 1, 1, 1, 1};
    v[5] = '{32, 1, 1, 1, 1};
    v[6] = '{33, 1, 0, 1, 2};
    v[7] = '{2, 1, 1, 1, 2};
    repeat (3) @(negedge clk);
    check("rst_out_data", out_data, '0);
    check("rst_out_data_wr", 134'(out_data_wr), '0);
    check("rst_out_valid_wr", 134'({out_valid, out_valid_wr}), '0);
    check("rst_counters", 134'({drop_num, err_num}), '0);
    rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      send_pkt(v[i].n, v[i].good, v[i].exp_out, 16'(i));
      wait_drain(300);
      if (i == 0) check("head_latency", 134'(head_cyc - tail_cyc), 134'(3));
      check("drop_num", 134'(drop_num), 134'(v[i].drop));
      check("err_num", 134'(err_num), 134'(v[i].err));
    end
`ifdef SSM_SAMPLE_BUF_STAT_EN
    check("buf_used_empty", 134'(buf_used), '0);
`endif
    put_word(2'b01, 16'h100, 0, 0, 0, 0);
    put_word(2'b11, 16'h100, 1, 0, 0, 0);
    put_word(2'b01, 16'h101, 0, 0, 0, 0);
    put_word(2'b11, 16'h101, 1, 0, 0, 0);
    put_word(2'b10, 16'h101, 2, 1, 1, 0);
    @(negedge clk);
    idle_in();
    send_pkt(3, 1, 1, 16'h102);
    wait_drain(300);
    check("early_head_err", 134'(err_num), 134'(3));
    check("early_head_drop", 134'(drop_num), 134'(1));
    out_alf = 1;
    rx0 = rx_words;
    for (int p = 0; p < 9; p++) send_pkt(32, 1, p < 8, 16'(16'h200 + p));
    repeat (10) @(negedge clk);
    check("alf_holds_output", 134'(rx_words), 134'(rx0));
    check("full_drop", 134'(drop_num), 134'(2));
`ifdef SSM_SAMPLE_BUF_STAT_EN
    check("buf_used_full", 134'(buf_used), 134'(256));
`endif
    out_alf = 0;
    wait_drain(1000);
    check("full_pkts", 134'(rx_pkts), 134'(exp_pkts));
    for (int p = 0; p < 300; p++) send_pkt(5, 1, 1, 16'(16'h1000 + p));
    wait_drain(500);
    check("wrap_pkts", 134'(rx_pkts), 134'(exp_pkts));
    check("wrap_drop", 134'(drop_num), 134'(2));
`ifdef SSM_SAMPLE_BUF_STAT_EN
    check("out_pkt_num", 134'(out_pkt_num), 134'(exp_pkts));
`endif
    out_alf = 1;
    send_pkt(4, 1, 1, 16'h300);
    put_word(2'b01, 16'h301, 0, 0, 0, 0);
    put_word(2'b11, 16'h301, 1, 0, 0, 0);
    put_word(2'b10, 16'h301, 2, 1, 0, 0);
    cnt_rst = 1;
    @(negedge clk);
    cnt_rst = 0;
    idle_in();
    check("cnt_rst_drop", 134'(drop_num), '0);
    check("cnt_rst_err", 134'(err_num), '0);
    out_alf = 0;
    wait_drain(300);
    check("cnt_rst_pkts", 134'(rx_pkts), 134'(exp_pkts));
    out_alf = 1;
    send_pkt(3, 0, 0, 16'h400);
    send_pkt(4, 1, 1, 16'h401);
    put_word(2'b01, 16'h402, 0, 0, 0, 0);
    put_word(2'b11, 16'h402, 1, 0, 0, 0);
    check("pre_reset_drop", 134'(drop_num), 134'(1));
    #2 rst_n = 0;
    exp_q.delete();
    exp_pkts--;
    rx_pkts = exp_pkts;
    #1;
    check("async_rst_out", 134'({out_data_wr, out_valid_wr, drop_num}), '0);
    @(negedge clk);
    idle_in();
    rst_n = 1;
    out_alf = 0;
    rx0 = rx_words;
    repeat (20) @(negedge clk);
    check("reset_flushed", 134'(rx_words), 134'(rx0));
    send_pkt(3, 1, 1, 16'h500);
    wait_drain(300);
    check("post_reset_pkts", 134'(rx_pkts), 134'(exp_pkts));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
